// File: rtl/axis_phase_generator_mc.sv
// Multi-channel NCO phase accumulator with a single AXI4-Stream master output and framed tlast.
// Optional macro AXIS_PHASE_GEN_TUSER_EN adds m_axis_tuser marking the first beat after start/sync.
module axis_phase_generator_mc #(
  parameter int CHANNELS         = 2,
  parameter int PHASE_WIDTH      = 30,
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int FRAME_LEN        = 1024
) (
  input  logic                               aclk,
  input  logic                               areset,
  input  logic                               cfg_enable,
  input  logic                               cfg_sync,
  input  logic [CHANNELS*PHASE_WIDTH-1:0]      cfg_data,
  input  logic [CHANNELS*PHASE_WIDTH-1:0]      cfg_offset,
  input  logic                               m_axis_tready,
  output logic                               m_axis_tvalid,
  output logic [CHANNELS*AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                               m_axis_tlast
`ifdef AXIS_PHASE_GEN_TUSER_EN
  ,
  output logic                               m_axis_tuser
`endif
);

  localparam int IDX_W = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t                      r_state;
  state_t                      w_state_next;
  logic [PHASE_WIDTH-1:0]      r_acc      [CHANNELS];
  logic [AXIS_TDATA_WIDTH-1:0] r_lane     [CHANNELS];
  logic [PHASE_WIDTH-1:0]      w_acc_next [CHANNELS];
  logic [PHASE_WIDTH-1:0]      w_phase_next [CHANNELS];
  logic [PHASE_WIDTH-1:0]      w_offset   [CHANNELS];
  logic [IDX_W-1:0]            r_idx;
  logic [IDX_W-1:0]            w_idx_next;
  logic                        r_tlast;
  logic                        r_sync_pending;
  logic                        w_hs;
  logic                        w_load;
  logic                        w_step;
  logic                        w_stop;
  logic                        w_resync;

  function automatic logic [AXIS_TDATA_WIDTH-1:0] sext(input logic [PHASE_WIDTH-1:0] p);
    return AXIS_TDATA_WIDTH'($signed(p));
  endfunction

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    assign w_offset[k]     = cfg_offset[k*PHASE_WIDTH +: PHASE_WIDTH];
    assign w_acc_next[k]   = r_acc[k] + cfg_data[k*PHASE_WIDTH +: PHASE_WIDTH];
    assign w_phase_next[k] = w_acc_next[k] + w_offset[k];
    assign m_axis_tdata[k*AXIS_TDATA_WIDTH +: AXIS_TDATA_WIDTH] = r_lane[k];
  end

  assign m_axis_tvalid = (r_state == S_RUN);
  assign m_axis_tlast  = r_tlast;
  assign w_hs          = m_axis_tvalid & m_axis_tready;
  assign w_idx_next    = (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
  assign w_load        = w_step ? 1'b0 : 1'b0;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Stop wins over a pending sync: the frame ends and the block parks in IDLE.
  always_comb begin
    w_state_next = r_state;
    w_step       = 1'b0;
    w_stop       = 1'b0;
    w_resync     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cfg_enable) begin
          w_state_next = S_RUN;
          w_resync     = 1'b1;
        end
      end
      S_RUN: begin
        if (w_hs) begin
          if (r_tlast && !cfg_enable) begin
            w_state_next = S_IDLE;
            w_stop       = 1'b1;
          end else if (r_sync_pending || cfg_sync) begin
            w_resync = 1'b1;
          end else begin
            w_step = 1'b1;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_sync_pending <= 1'b0;
    end else if (r_state != S_RUN || w_stop || w_resync) begin
      r_sync_pending <= 1'b0;
    end else if (cfg_sync) begin
      r_sync_pending <= 1'b1;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int k = 0; k < CHANNELS; k++) begin
        r_acc[k]  <= '0;
        r_lane[k] <= '0;
      end
      r_idx   <= '0;
      r_tlast <= 1'b0;
    end else if (w_resync || w_load) begin
      for (int k = 0; k < CHANNELS; k++) begin
        r_acc[k]  <= '0;
        r_lane[k] <= sext(w_offset[k]);
      end
      r_idx   <= '0;
      r_tlast <= 1'b0;
    end else if (w_step) begin
      for (int k = 0; k < CHANNELS; k++) begin
        r_acc[k]  <= w_acc_next[k];
        r_lane[k] <= sext(w_phase_next[k]);
      end
      r_idx   <= w_idx_next;
      r_tlast <= (w_idx_next == LAST_IDX);
    end else if (w_stop) begin
      r_idx   <= '0;
      r_tlast <= 1'b0;
    end
  end

`ifdef AXIS_PHASE_GEN_TUSER_EN
  logic r_tuser;
  assign m_axis_tuser = r_tuser;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset)                r_tuser <= 1'b0;
    else if (w_resync)         r_tuser <= 1'b1;
    else if (w_step || w_stop) r_tuser <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_axis_phase_generator_mc.sv
// Directed bench for axis_phase_generator_mc: start, stall, wrap/sign-extension, stop, sync, async reset.
module tb_axis_phase_generator_mc;

  localparam int CH  = 2;
  localparam int PW  = 30;
  localparam int TW  = 32;
  localparam int FL  = 4;

  logic              aclk = 1'b0;
  logic              areset;
  logic              cfg_enable;
  logic              cfg_sync;
  logic [CH*PW-1:0]  cfg_data;
  logic [CH*PW-1:0]  cfg_offset;
  logic              m_axis_tready;
  logic              m_axis_tvalid;
  logic [CH*TW-1:0]  m_axis_tdata;
  logic              m_axis_tlast;
`ifdef AXIS_PHASE_GEN_TUSER_EN
  logic              m_axis_tuser;
`endif

  int n_checks = 0;
  int n_errors = 0;

  axis_phase_generator_mc #(
    .CHANNELS(CH), .PHASE_WIDTH(PW), .AXIS_TDATA_WIDTH(TW), .FRAME_LEN(FL)
  ) dut (
    .aclk(aclk), .areset(areset), .cfg_enable(cfg_enable), .cfg_sync(cfg_sync),
    .cfg_data(cfg_data), .cfg_offset(cfg_offset), .m_axis_tready(m_axis_tready),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast)
`ifdef AXIS_PHASE_GEN_TUSER_EN
    , .m_axis_tuser(m_axis_tuser)
`endif
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check_beat(input string tag, input logic [31:0] l0, input logic [31:0] l1,
                            input logic vld, input logic last);
    check({tag, ".vld"},  64'(m_axis_tvalid), 64'(vld));
    check({tag, ".lane0"}, 64'(m_axis_tdata[31:0]), 64'(l0));
    check({tag, ".lane1"}, 64'(m_axis_tdata[63:32]), 64'(l1));
    check({tag, ".last"}, 64'(m_axis_tlast), 64'(last));
  endtask

  function automatic logic [CH*PW-1:0] pack(input logic [PW-1:0] c1, input logic [PW-1:0] c0);
    return {c1, c0};
  endfunction

  initial begin
    areset = 1'b1; cfg_enable = 1'b0; cfg_sync = 1'b0;
    cfg_data = '0; cfg_offset = '0; m_axis_tready = 1'b0;
    tick(); tick();
    check_beat("reset", 32'h0, 32'h0, 1'b0, 1'b0);
    areset = 1'b0;

    // Start: lane0 steps by 1, lane1 by 3
    cfg_data = pack(30'd3, 30'd1); m_axis_tready = 1'b1;
    tick();
    check_beat("idle", 32'h0, 32'h0, 1'b0, 1'b0);
    cfg_enable = 1'b1;
    for (int n = 0; n < 6; n++) begin
      tick();
      check_beat($sformatf("start.b%0d", n), 32'(n), 32'(3*n), 1'b1, (n % FL) == FL-1);
    end

    // Stall on beat 5 (5,15) while cfg_data churns
    m_axis_tready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      cfg_data = pack(30'(100 + n), 30'(200 + 7*n));
      tick();
      check_beat($sformatf("stall.%0d", n), 32'd5, 32'd15, 1'b1, 1'b0);
    end
    cfg_data = pack(30'd10, 30'd2); m_axis_tready = 1'b1;
    tick();
    check_beat("post_stall.b6", 32'd7, 32'd25, 1'b1, 1'b0);
    tick();
    check_beat("post_stall.b7", 32'd9, 32'd35, 1'b1, 1'b1);

    // Async reset between edges
    #2;
    areset = 1'b1;
    #1;
    check_beat("async_rst", 32'h0, 32'h0, 1'b0, 1'b0);
    cfg_data   = pack(30'd1, 30'd1);
    cfg_offset = pack(30'h3000_0001, 30'd5);
    tick();
    check_beat("async_rst_hold", 32'h0, 32'h0, 1'b0, 1'b0);
    areset = 1'b0;
    tick();
    check_beat("restart.b0", 32'd5, 32'hF000_0001, 1'b1, 1'b0);

    // Stop requested at beat 1: frame completes, then idle with held data
    tick();
    check_beat("stop.b1", 32'd6, 32'hF000_0002, 1'b1, 1'b0);
    cfg_enable = 1'b0;
    tick();
    check_beat("stop.b2", 32'd7, 32'hF000_0003, 1'b1, 1'b0);
    tick();
    check_beat("stop.b3", 32'd8, 32'hF000_0004, 1'b1, 1'b1);
    tick();
    check_beat("stopped", 32'd8, 32'hF000_0004, 1'b0, 1'b0);
    tick();
    check_beat("stopped2", 32'd8, 32'hF000_0004, 1'b0, 1'b0);

    // Wrap and sign extension on lane0
    cfg_data = pack(30'd0, 30'h1000_0000); cfg_offset = '0; cfg_enable = 1'b1;
    tick();
    check_beat("wrap.b0", 32'h0000_0000, 32'h0, 1'b1, 1'b0);
    tick();
    check_beat("wrap.b1", 32'h1000_0000, 32'h0, 1'b1, 1'b0);
    tick();
    check_beat("wrap.b2", 32'hE000_0000, 32'h0, 1'b1, 1'b0);
    tick();
    check_beat("wrap.b3", 32'hF000_0000, 32'h0, 1'b1, 1'b1);
    tick();
    check_beat("wrap.b4", 32'h0000_0000, 32'h0, 1'b1, 1'b0);

    // Sync: climb to 0x1E, pulse sync during a stall with a new offset
    areset = 1'b1; #1; areset = 1'b0;
    cfg_data = pack(30'd1, 30'd5);
    for (int n = 0; n < 7; n++) begin
      tick();
      check_beat($sformatf("presync.b%0d", n), 32'(5*n), 32'(n), 1'b1, (n % FL) == FL-1);
    end
    m_axis_tready = 1'b0; cfg_sync = 1'b1; cfg_offset = pack(30'd0, 30'd7);
    tick();
    cfg_sync = 1'b0;
    check_beat("sync.stall0", 32'h1E, 32'd6, 1'b1, 1'b0);
    tick();
    check_beat("sync.stall1", 32'h1E, 32'd6, 1'b1, 1'b0);
    tick();
    check_beat("sync.stall2", 32'h1E, 32'd6, 1'b1, 1'b0);
    m_axis_tready = 1'b1;
    tick();
    check_beat("sync.b0", 32'h07, 32'd0, 1'b1, 1'b0);
    tick();
    check_beat("sync.b1", 32'h0C, 32'd1, 1'b1, 1'b0);
    tick();
    check_beat("sync.b2", 32'h11, 32'd2, 1'b1, 1'b0);
    tick();
    check_beat("sync.b3", 32'h16, 32'd3, 1'b1, 1'b1);

    // Sync pulse coinciding with a handshake applies immediately
    cfg_sync = 1'b1;
    tick();
    cfg_sync = 1'b0;
    check_beat("sync_hs.b0", 32'h07, 32'd0, 1'b1, 1'b0);
    tick();
    check_beat("sync_hs.b1", 32'h0C, 32'd1, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
